bac_round_ctrl: RTL and testbench

BAC_ROUND_CTRL -- requirements
Module: bac_round_ctrl

---
 rtl/bac_pkg.sv | 24 ++
 rtl/bac_banker_rule.sv | 30 +++
 rtl/bac_round_ctrl.sv | 124 ++++++++++++
 tb/tb_bac_round_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bac_pkg.sv
// Shared definitions for the baccarat round controller: FSM states,
// rule-mode encodings and the natural-hand threshold.
package bac_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHK,
    S_P3,
    S_DCHK,
    S_D3,
    S_RES,
    S_DONE,
    S_CLR
  } state_t;

  localparam logic MODE_STD    = 1'b1;  // full banker third-card table
  localparam logic MODE_SIMPLE = 1'b0;  // banker draws iff dscore <= 5

  localparam logic [3:0] NATURAL_THRESH = 4'd8;

endpackage

// File: rtl/bac_banker_rule.sv
// Banker third-card decision, purely combinational.
// Evaluated once the player's third card is known.
module bac_banker_rule
  import bac_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       mode,
  output logic       draw
);

  // Decode the banker draw decision from the banker total and the player's third card.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    draw = 1'b0;
    if (mode == MODE_SIMPLE) begin
      draw = (dscore <= 4'd5);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (pcard3 != 4'd8);
        4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
        4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
        4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/bac_round_ctrl.sv
// Baccarat round controller: sequences card loads, applies the drawing
// rules, registers the result lights and keeps saturating win/tie tallies.
module bac_round_ctrl
  import bac_pkg::*;
#(
  parameter int CNT_W             = 8,
  parameter bit STD_RULES_DEFAULT = 1'b1
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pscore,
  input  logic [3:0]       pcard3,
  input  logic             rule_mode,
  input  logic             next_round,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             clear_hands,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             round_done,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;
  logic   mode_q;
  logic   banker_draw;
  logic   natural;

  assign natural = (pscore >= NATURAL_THRESH) || (dscore >= NATURAL_THRESH);

  bac_banker_rule u_banker_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .mode   (mode_q),
    .draw   (banker_draw)
  );

  // State register; reset returns to P1 even mid-round.
  always_ff @(posedge slow_clock or negedge resetb) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!resetb) state <= S_P1;
    else         state <= state_nxt;
  end

  // Next-state logic: fixed deal sequence, then natural/draw decisions.
  always_comb begin
    state_nxt = state;
    case (state)
      S_P1:   state_nxt = S_D1;
      S_D1:   state_nxt = S_P2;
      S_P2:   state_nxt = S_D2;
      S_D2:   state_nxt = S_CHK;
      S_CHK: begin
        if (natural)                state_nxt = S_RES;
        else if (pscore <= 4'd5)    state_nxt = S_P3;
        else if (dscore <= 4'd5)    state_nxt = S_D3;
        else                        state_nxt = S_RES;
      end
      S_P3:   state_nxt = S_DCHK;
      S_DCHK: state_nxt = banker_draw ? S_D3 : S_RES;
      S_D3:   state_nxt = S_RES;
      S_RES:  state_nxt = S_DONE;
      S_DONE: state_nxt = next_round ? S_CLR : S_DONE;
      S_CLR:  state_nxt = S_P1;
      default: state_nxt = S_P1;
    endcase
  end

  // Moore strobes and status, decoded straight from the state.
  always_comb begin
    load_pcard1 = (state == S_P1);
    load_dcard1 = (state == S_D1);
    load_pcard2 = (state == S_P2);
    load_dcard2 = (state == S_D2);
    load_pcard3 = (state == S_P3);
    load_dcard3 = (state == S_D3);
    clear_hands = (state == S_CLR);
    round_done  = (state == S_DONE);
  end

  // Rule mode is captured while dealing the first card and frozen for the round.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)              mode_q <= STD_RULES_DEFAULT;
    else if (state == S_P1)   mode_q <= rule_mode;
  end

  // Result lights and saturating tallies, updated once per round in RES.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      player_wins      <= '0;
      dealer_wins      <= '0;
      ties             <= '0;
    end else if (state == S_RES) begin
      if (pscore > dscore) begin
        player_win_light <= 1'b1;
        dealer_win_light <= 1'b0;
        if (player_wins != CNT_MAX) player_wins <= player_wins + 1'b1;
      end else if (pscore < dscore) begin
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b1;
        if (dealer_wins != CNT_MAX) dealer_wins <= dealer_wins + 1'b1;
      end else begin
        player_win_light <= 1'b1;
        dealer_win_light <= 1'b1;
        if (ties != CNT_MAX) ties <= ties + 1'b1;
      end
    end else if (state == S_CLR) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bac_round_ctrl.sv
// Directed bench for bac_round_ctrl: hand-computed rounds covering naturals,
// both rule sets, mode latching, ties, saturation and asynchronous reset.
`timescale 1ns/1ps
module tb_bac_round_ctrl;

  localparam int CNT_W = 2;
  localparam int R_PLAYER = 0;
  localparam int R_DEALER = 1;
  localparam int R_TIE    = 2;

  logic             slow_clock = 1'b0;
  logic             resetb     = 1'b0;
  logic [3:0]       dscore     = '0;
  logic [3:0]       pscore     = '0;
  logic [3:0]       pcard3     = '0;
  logic             rule_mode  = 1'b1;
  logic             next_round = 1'b0;
  logic             load_pcard1, load_pcard2, load_pcard3;
  logic             load_dcard1, load_dcard2, load_dcard3;
  logic             clear_hands, player_win_light, dealer_win_light, round_done;
  logic [CNT_W-1:0] player_wins, dealer_wins, ties;

  int n_checks = 0;
  int n_errors = 0;

  always #5 slow_clock = ~slow_clock;

  bac_round_ctrl #(.CNT_W(CNT_W), .STD_RULES_DEFAULT(1'b1)) dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .dscore           (dscore),
    .pscore           (pscore),
    .pcard3           (pcard3),
    .rule_mode        (rule_mode),
    .next_round       (next_round),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .clear_hands      (clear_hands),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .round_done       (round_done),
    .player_wins      (player_wins),
    .dealer_wins      (dealer_wins),
    .ties             (ties)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Play one round from P1 to DONE; the bench acts as the card datapath with
  // fixed scores. mode0 is presented during P1, mode1 from D1 onwards.
  task automatic run_round(input string tag,
                           input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                           input logic mode0, input logic mode1, input logic nr_during,
                           input int exp_p3, input int exp_d3, input int exp_cyc, input int exp_res,
                           input int exp_pw, input int exp_dw, input int exp_ti);
    int  n_p3 = 0;
    int  n_d3 = 0;
    int  cyc  = 0;
    bit  done = 1'b0;
    pscore = ps; dscore = ds; pcard3 = pc3; rule_mode = mode0; next_round = nr_during;
    check({tag, "_p1"}, load_pcard1, 1);
    while (!done && cyc < 20) begin
      @(negedge slow_clock);
      cyc++;
      if (cyc == 1) rule_mode = mode1;
      n_p3 += int'(load_pcard3);
      n_d3 += int'(load_dcard3);
      if (round_done) done = 1'b1;
    end
    next_round = 1'b0;
    check({tag, "_reached_done"}, done, 1);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_pcard3_strobes"}, n_p3, exp_p3);
    check({tag, "_dcard3_strobes"}, n_d3, exp_d3);
    check({tag, "_player_light"}, player_win_light, (exp_res != R_DEALER) ? 1 : 0);
    check({tag, "_dealer_light"}, dealer_win_light, (exp_res != R_PLAYER) ? 1 : 0);
    check({tag, "_player_wins"}, player_wins, exp_pw);
    check({tag, "_dealer_wins"}, dealer_wins, exp_dw);
    check({tag, "_ties"}, ties, exp_ti);
  endtask

  // Linger in DONE, then request the next round and follow CLR back to P1.
  task automatic finish_round(input string tag, input int exp_res);
    repeat (2) begin
      @(negedge slow_clock);
      check({tag, "_done_hold"}, round_done, 1);
      check({tag, "_hold_plight"}, player_win_light, (exp_res != R_DEALER) ? 1 : 0);
      check({tag, "_hold_dlight"}, dealer_win_light, (exp_res != R_PLAYER) ? 1 : 0);
    end
    next_round = 1'b1;
    @(negedge slow_clock);
    next_round = 1'b0;
    check({tag, "_clr_pulse"}, clear_hands, 1);
    check({tag, "_clr_not_done"}, round_done, 0);
    check({tag, "_clr_no_pcard1"}, load_pcard1, 0);
    @(negedge slow_clock);
    check({tag, "_clr_once"}, clear_hands, 0);
    check({tag, "_lights_off"}, {player_win_light, dealer_win_light}, 0);
    check({tag, "_back_p1"}, load_pcard1, 1);
  endtask

  initial begin
    // Reset state, observed before any clock edge.
    #1;
    check("rst_pcard1", load_pcard1, 1);
    check("rst_other_strobes",
          {load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3}, 0);
    check("rst_clear_hands", clear_hands, 0);
    check("rst_round_done", round_done, 0);
    check("rst_lights", {player_win_light, dealer_win_light}, 0);
    check("rst_counters", {player_wins, dealer_wins, ties}, 0);
    repeat (2) @(negedge slow_clock);
    resetb = 1'b1;
    check("post_rst_pcard1", load_pcard1, 1);

    //        tag        ps     ds     pc3    m0    m1    nr    p3 d3 cyc res       pw dw ti
    run_round("natural", 4'd8, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_PLAYER, 1, 0, 0);
    finish_round("natural", R_PLAYER);
    run_round("std_stand", 4'd4, 4'd6, 4'd5, 1'b1, 1'b1, 1'b1, 1, 0, 8, R_DEALER, 1, 1, 0);
    finish_round("std_stand", R_DEALER);
    run_round("simp_draw", 4'd4, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1, 1, 9, R_DEALER, 1, 2, 0);
    finish_round("simp_draw", R_DEALER);
    run_round("latch_std", 4'd4, 4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 1, 0, 8, R_DEALER, 1, 3, 0);
    finish_round("latch_std", R_DEALER);
    run_round("latch_simp", 4'd3, 4'd4, 4'd9, 1'b0, 1'b1, 1'b0, 1, 1, 9, R_DEALER, 1, 3, 0);
    finish_round("latch_simp", R_DEALER);
    run_round("tie", 4'd7, 4'd7, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_TIE, 1, 3, 1);
    finish_round("tie", R_TIE);
    run_round("d3_pc8", 4'd2, 4'd3, 4'd8, 1'b1, 1'b1, 1'b0, 1, 0, 8, R_DEALER, 1, 3, 1);
    finish_round("d3_pc8", R_DEALER);
    run_round("p6_d5", 4'd6, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0, 0, 1, 7, R_PLAYER, 2, 3, 1);
    finish_round("p6_d5", R_PLAYER);
    run_round("d6_pc6", 4'd1, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 1, 1, 9, R_DEALER, 2, 3, 1);
    finish_round("d6_pc6", R_DEALER);
    run_round("nat_9_0", 4'd9, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_PLAYER, 3, 3, 1);
    finish_round("nat_9_0", R_PLAYER);
    run_round("nat_tie", 4'd8, 4'd8, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_TIE, 3, 3, 2);
    finish_round("nat_tie", R_TIE);
    run_round("sat_p4", 4'd9, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_PLAYER, 3, 3, 2);
    finish_round("sat_p4", R_PLAYER);
    run_round("d7_stand", 4'd5, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0, 1, 0, 8, R_DEALER, 3, 3, 2);
    finish_round("d7_stand", R_DEALER);
    run_round("sat_p5", 4'd7, 4'd6, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_PLAYER, 3, 3, 2);
    finish_round("sat_p5", R_PLAYER);
    run_round("d4_pc2", 4'd0, 4'd4, 4'd2, 1'b1, 1'b1, 1'b0, 1, 1, 9, R_DEALER, 3, 3, 2);
    finish_round("d4_pc2", R_DEALER);

    // Asynchronous reset while the player's third card is being loaded.
    pscore = 4'd4; dscore = 4'd6; pcard3 = 4'd5; rule_mode = 1'b1;
    repeat (5) @(negedge slow_clock);
    check("arst_in_p3", load_pcard3, 1);
    #2 resetb = 1'b0;
    #1;
    check("arst_p3_pcard1", load_pcard1, 1);
    check("arst_p3_pcard3", load_pcard3, 0);
    check("arst_p3_counters", {player_wins, dealer_wins, ties}, 0);
    check("arst_p3_round_done", round_done, 0);
    @(negedge slow_clock);
    resetb = 1'b1;

    // Counters restart from zero; then reset again while the lights are lit.
    run_round("post_arst", 4'd8, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 0, 0, 6, R_PLAYER, 1, 0, 0);
    #2 resetb = 1'b0;
    #1;
    check("arst_done_lights", {player_win_light, dealer_win_light}, 0);
    check("arst_done_round_done", round_done, 0);
    check("arst_done_pcard1", load_pcard1, 1);
    check("arst_done_counters", {player_wins, dealer_wins, ties}, 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);
    check("post_arst_d1", load_dcard1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
